// File: rtl/nnrv_mem_pkg.sv
// Shared constants and helpers for the nnrv memory-access stage:
// datapath sizing, FSM state encodings and load-width decoding.
package nnrv_mem_pkg;

  localparam int NNRV_XLEN       = 64;
  localparam int NNRV_MASK_WIDTH = 8;

  localparam logic [0:0] MEM_IDLE = 1'b0;
  localparam logic [0:0] MEM_BUSY = 1'b1;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_width_e;

  // Lane-normalised byte mask to access width; irregular patterns read as a doubleword.
  function automatic ld_width_e ld_width(input logic [7:0] lane_mask);
    case (lane_mask)
      8'h01:   ld_width = LD_B;
      8'h03:   ld_width = LD_H;
      8'h0F:   ld_width = LD_W;
      8'hFF:   ld_width = LD_D;
      default: ld_width = LD_D;
    endcase
  endfunction

endpackage

// File: rtl/nnrv_load_align.sv
// Combinational load aligner: shifts the addressed lane of a RAM word down
// to bit 0 and zero- or sign-extends it according to the access width.
module nnrv_load_align
  import nnrv_mem_pkg::*;
#(
  parameter int XLEN = NNRV_XLEN
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      sh,
  input  logic [7:0]      mask,
  input  logic            sign,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] lane_s;
  logic [7:0]      lane_mask_s;

  assign lane_s      = rdata >> {sh, 3'b000};
  assign lane_mask_s = mask >> sh;

  // Extend the lane from the top byte of the decoded width.
  always_comb begin
    value = lane_s;
    case (ld_width(lane_mask_s))
      LD_B:    value = {{(XLEN-8){sign & lane_s[7]}}, lane_s[7:0]};
      LD_H:    value = {{(XLEN-16){sign & lane_s[15]}}, lane_s[15:0]};
      LD_W:    value = {{(XLEN-32){sign & lane_s[31]}}, lane_s[31:0]};
      LD_D:    value = lane_s;
      default: value = lane_s;
    endcase
  end

endmodule

// File: rtl/nnrv_mem.sv
// Memory-access stage: passes ALU results to writeback, runs one RAM access
// at a time over a req/ack handshake and stalls upstream while it is pending.
module nnrv_mem
  import nnrv_mem_pkg::*;
#(
  parameter int XLEN       = NNRV_XLEN,
  parameter int MASK_WIDTH = NNRV_MASK_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ex_rd_en,
  input  logic [4:0]            i_ex_rd,
  input  logic [XLEN-1:0]       i_ex_rd_reg,
  input  logic                  i_ex_ram_rd_en,
  input  logic                  i_ex_ram_wr_en,
  input  logic [XLEN-1:0]       i_ex_ram_addr,
  input  logic [XLEN-1:0]       i_ex_ram_data,
  input  logic [MASK_WIDTH-1:0] i_ex_ram_mask,
  input  logic                  i_ex_sign,
  output logic                  o_stall,
  output logic                  o_ram_req,
  output logic                  o_ram_we,
  output logic [XLEN-1:0]       o_ram_addr,
  output logic [XLEN-1:0]       o_ram_wdata,
  output logic [MASK_WIDTH-1:0] o_ram_wmask,
  input  logic                  i_ram_ack,
  input  logic [XLEN-1:0]       i_ram_rdata,
  output logic                  o_wb_rd_en,
  output logic [4:0]            o_wb_rd,
  output logic [XLEN-1:0]       o_wb_rd_reg,
  output logic                  o_id_rd_ready
);

  logic [0:0]            state_r;
  logic                  load_r;
  logic                  ld_rd_en_r;
  logic [4:0]            ld_rd_r;
  logic [2:0]            sh_r;
  logic [MASK_WIDTH-1:0] mask_r;
  logic                  sign_r;
  logic                  req_r;
  logic                  we_r;
  logic [XLEN-1:0]       addr_r;
  logic [XLEN-1:0]       wdata_r;
  logic [MASK_WIDTH-1:0] wmask_r;
  logic                  wb_rd_en_r;
  logic [4:0]            wb_rd_r;
  logic [XLEN-1:0]       wb_rd_reg_r;
  logic                  mem_op_s;
  logic                  stall_s;
  logic [XLEN-1:0]       load_value_s;

  assign mem_op_s = i_ex_ram_rd_en | i_ex_ram_wr_en;

  nnrv_load_align #(.XLEN(XLEN)) u_align (
    .rdata (i_ram_rdata),
    .sh    (sh_r),
    .mask  (mask_r),
    .sign  (sign_r),
    .value (load_value_s)
  );

  // Access FSM, RAM request registers and writeback registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= MEM_IDLE;
      load_r      <= 1'b0;
      ld_rd_en_r  <= 1'b0;
      ld_rd_r     <= 5'd0;
      sh_r        <= 3'd0;
      mask_r      <= '0;
      sign_r      <= 1'b0;
      req_r       <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      wmask_r     <= '0;
      wb_rd_en_r  <= 1'b0;
      wb_rd_r     <= 5'd0;
      wb_rd_reg_r <= '0;
    end else begin
      case (state_r)
        MEM_IDLE: begin
          if (mem_op_s) begin
            // A load takes priority; a simultaneous store is dropped.
            state_r    <= MEM_BUSY;
            req_r      <= 1'b1;
            we_r       <= ~i_ex_ram_rd_en;
            load_r     <= i_ex_ram_rd_en;
            addr_r     <= {i_ex_ram_addr[XLEN-1:3], 3'b000};
            wdata_r    <= i_ex_ram_rd_en ? '0 : i_ex_ram_data;
            wmask_r    <= i_ex_ram_rd_en ? '0 : i_ex_ram_mask;
            mask_r     <= i_ex_ram_mask;
            sh_r       <= i_ex_ram_addr[2:0];
            sign_r     <= i_ex_sign;
            ld_rd_en_r <= i_ex_rd_en & (i_ex_rd != 5'd0);
            ld_rd_r    <= i_ex_rd;
            wb_rd_en_r <= 1'b0;
          end else begin
            wb_rd_en_r  <= i_ex_rd_en & (i_ex_rd != 5'd0);
            wb_rd_r     <= i_ex_rd;
            wb_rd_reg_r <= i_ex_rd_reg;
          end
        end
        MEM_BUSY: begin
          if (i_ram_ack) begin
            state_r     <= MEM_IDLE;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            wb_rd_en_r  <= load_r & ld_rd_en_r;
            wb_rd_r     <= ld_rd_r;
            wb_rd_reg_r <= load_r ? load_value_s : '0;
          end else begin
            wb_rd_en_r  <= 1'b0;
          end
        end
        default: begin
          state_r    <= MEM_IDLE;
          req_r      <= 1'b0;
          wb_rd_en_r <= 1'b0;
        end
      endcase
    end
  end

  // Stall covers the accept cycle and every waiting cycle; it drops with ack.
  always_comb begin
    stall_s = 1'b0;
    if (i_rst) begin
      stall_s = 1'b0;
    end else if (state_r == MEM_IDLE) begin
      stall_s = mem_op_s;
    end else begin
      stall_s = ~i_ram_ack;
    end
  end

  assign o_stall       = stall_s;
  assign o_ram_req     = req_r;
  assign o_ram_we      = we_r;
  assign o_ram_addr    = addr_r;
  assign o_ram_wdata   = wdata_r;
  assign o_ram_wmask   = wmask_r;
  assign o_wb_rd_en    = wb_rd_en_r;
  assign o_wb_rd       = wb_rd_r;
  assign o_wb_rd_reg   = wb_rd_reg_r;
  assign o_id_rd_ready = wb_rd_en_r;

endmodule

// File: tb/tb_nnrv_mem.sv
// Randomised self-checking bench for nnrv_mem with a behavioural model of
// pass-through results, RAM handshake timing and load alignment.
module tb_nnrv_mem;

  logic        i_clk;
  logic        i_rst;
  logic        i_ex_rd_en;
  logic [4:0]  i_ex_rd;
  logic [63:0] i_ex_rd_reg;
  logic        i_ex_ram_rd_en;
  logic        i_ex_ram_wr_en;
  logic [63:0] i_ex_ram_addr;
  logic [63:0] i_ex_ram_data;
  logic [7:0]  i_ex_ram_mask;
  logic        i_ex_sign;
  logic        o_stall;
  logic        o_ram_req;
  logic        o_ram_we;
  logic [63:0] o_ram_addr;
  logic [63:0] o_ram_wdata;
  logic [7:0]  o_ram_wmask;
  logic        i_ram_ack;
  logic [63:0] i_ram_rdata;
  logic        o_wb_rd_en;
  logic [4:0]  o_wb_rd;
  logic [63:0] o_wb_rd_reg;
  logic        o_id_rd_ready;

  int n_chk  = 0;
  int n_pass = 0;

  nnrv_mem dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ex_rd_en(i_ex_rd_en), .i_ex_rd(i_ex_rd), .i_ex_rd_reg(i_ex_rd_reg),
    .i_ex_ram_rd_en(i_ex_ram_rd_en), .i_ex_ram_wr_en(i_ex_ram_wr_en),
    .i_ex_ram_addr(i_ex_ram_addr), .i_ex_ram_data(i_ex_ram_data),
    .i_ex_ram_mask(i_ex_ram_mask), .i_ex_sign(i_ex_sign),
    .o_stall(o_stall), .o_ram_req(o_ram_req), .o_ram_we(o_ram_we),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata), .o_ram_wmask(o_ram_wmask),
    .i_ram_ack(i_ram_ack), .i_ram_rdata(i_ram_rdata),
    .o_wb_rd_en(o_wb_rd_en), .o_wb_rd(o_wb_rd), .o_wb_rd_reg(o_wb_rd_reg),
    .o_id_rd_ready(o_id_rd_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference load value: pick the addressed bytes arithmetically, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [63:0] addr,
                                           input logic [7:0] mask, input logic sign);
    int sh, m, nbytes;
    logic [63:0] v, lim;
    sh = int'(addr[2:0]);
    m = int'(mask) >> sh;
    nbytes = (m == 1) ? 1 : (m == 3) ? 2 : (m == 15) ? 4 : 8;
    v = rdata >> (8 * sh);
    if (nbytes < 8) begin
      lim = (64'd1 << (8 * nbytes)) - 64'd1;
      v = v & lim;
      if (sign && v[8*nbytes-1]) v = v | ~lim;
    end
    return v;
  endfunction

  task automatic clear_ex();
    i_ex_rd_en = 1'b0; i_ex_rd = 5'd0; i_ex_rd_reg = 64'd0;
    i_ex_ram_rd_en = 1'b0; i_ex_ram_wr_en = 1'b0; i_ex_ram_addr = 64'd0;
    i_ex_ram_data = 64'd0; i_ex_ram_mask = 8'd0; i_ex_sign = 1'b0;
  endtask

  // Non-memory op: one-cycle pass-through; a stray ack in idle must do nothing.
  task automatic do_alu(input logic en, input logic [4:0] rd, input logic [63:0] val);
    logic exp_en;
    clear_ex();
    i_ex_rd_en = en; i_ex_rd = rd; i_ex_rd_reg = val;
    i_ram_ack = 1'($urandom_range(0, 1)); i_ram_rdata = rnd64();
    @(negedge i_clk);
    chk("alu_stall", 64'(o_stall), 64'd0);
    chk("alu_req", 64'(o_ram_req), 64'd0);
    @(posedge i_clk); #1;
    exp_en = en && (rd != 5'd0);
    chk("alu_wb_en", 64'(o_wb_rd_en), 64'(exp_en));
    chk("alu_ready", 64'(o_id_rd_ready), 64'(exp_en));
    if (exp_en) begin
      chk("alu_wb_rd", 64'(o_wb_rd), 64'(rd));
      chk("alu_wb_reg", o_wb_rd_reg, val);
    end
    i_ram_ack = 1'b0;
  endtask

  // Memory op with ack arriving after 'delay' waiting cycles in BUSY.
  task automatic do_mem(input logic ld, input logic st, input logic [63:0] addr,
                        input logic [63:0] data, input logic [7:0] mask, input logic sign,
                        input logic [4:0] rd, input int delay, input logic [63:0] rdata);
    logic exp_en;
    clear_ex();
    i_ex_rd_en = ld; i_ex_rd = rd; i_ex_rd_reg = rnd64();
    i_ex_ram_rd_en = ld; i_ex_ram_wr_en = st; i_ex_ram_addr = addr;
    i_ex_ram_data = data; i_ex_ram_mask = mask; i_ex_sign = sign;
    @(negedge i_clk);
    chk("acc_stall", 64'(o_stall), 64'd1);
    chk("acc_req", 64'(o_ram_req), 64'd0);
    @(posedge i_clk); #1;
    for (int k = 0; k <= delay; k++) begin
      if (k == delay) begin i_ram_ack = 1'b1; i_ram_rdata = rdata; end
      else i_ram_rdata = rnd64();
      @(negedge i_clk);
      chk("busy_req", 64'(o_ram_req), 64'd1);
      chk("busy_we", 64'(o_ram_we), 64'(!ld));
      chk("busy_addr", o_ram_addr, addr & ~64'h7);
      if (!ld) begin
        chk("busy_wdata", o_ram_wdata, data);
        chk("busy_wmask", 64'(o_ram_wmask), 64'(mask));
      end
      chk("busy_stall", 64'(o_stall), 64'(k != delay));
      chk("busy_ready", 64'(o_id_rd_ready), 64'd0);
      chk("busy_wb_en", 64'(o_wb_rd_en), 64'd0);
      @(posedge i_clk); #1;
      i_ram_ack = 1'b0;
    end
    clear_ex();
    exp_en = ld && (rd != 5'd0);
    chk("done_req", 64'(o_ram_req), 64'd0);
    chk("done_wb_en", 64'(o_wb_rd_en), 64'(exp_en));
    chk("done_ready", 64'(o_id_rd_ready), 64'(exp_en));
    if (exp_en) begin
      chk("done_wb_rd", 64'(o_wb_rd), 64'(rd));
      chk("done_wb_reg", o_wb_rd_reg, ref_load(rdata, addr, mask, sign));
    end
  endtask

  initial begin
    int nb, sh, op;
    logic [7:0]  mask;
    logic [63:0] addr;
    i_rst = 1'b1; i_ram_ack = 1'b0; i_ram_rdata = 64'd0;
    clear_ex();
    #12;
    chk("rst_req", 64'(o_ram_req), 64'd0);
    chk("rst_wb_en", 64'(o_wb_rd_en), 64'd0);
    chk("rst_wb_reg", o_wb_rd_reg, 64'd0);
    chk("rst_stall", 64'(o_stall), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    do_alu(1'b1, 5'd5, 64'h1234);
    do_alu(1'b1, 5'd0, 64'hABCD);
    do_mem(1'b1, 1'b0, 64'h1003, 64'd0, 8'h08, 1'b1, 5'd10, 0, 64'h00000000_80000000);
    do_mem(1'b1, 1'b0, 64'h2006, 64'd0, 8'hC0, 1'b0, 5'd11, 1, 64'hBEEF_0000_0000_0000);
    do_mem(1'b0, 1'b1, 64'h3004, 64'hDEADBEEF_00000000, 8'hF0, 1'b0, 5'd0, 3, rnd64());
    do_mem(1'b1, 1'b0, 64'h4008, 64'd0, 8'hFF, 1'b1, 5'd12, 3, 64'h8123_4567_89AB_CDEF);
    do_mem(1'b1, 1'b1, 64'h5004, 64'h55, 8'hF0, 1'b1, 5'd13, 0, 64'h8765_4321_0000_0000);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      nb = 1 << $urandom_range(0, 3);
      sh = ($urandom_range(0, 7) / nb) * nb;
      mask = 8'(((1 << nb) - 1) << sh);
      if ($urandom_range(0, 7) == 0) mask = 8'($urandom_range(1, 255));
      addr = {rnd64() >> 3, 3'(sh)};
      case (op)
        0: do_alu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rnd64());
        1: do_mem(1'b0, 1'b1, addr, rnd64(), mask, 1'b0, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 4), rnd64());
        default: do_mem(1'b1, 1'($urandom_range(0, 1)), addr, rnd64(), mask,
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                        $urandom_range(0, 4), rnd64());
      endcase
    end

    // Reset in the middle of a pending load; the late ack must be ignored.
    clear_ex();
    i_ex_rd_en = 1'b1; i_ex_rd = 5'd7; i_ex_ram_rd_en = 1'b1;
    i_ex_ram_addr = 64'h6000; i_ex_ram_mask = 8'hFF;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("pre_rst_req", 64'(o_ram_req), 64'd1);
    #1 i_rst = 1'b1;
    #1;
    chk("mid_rst_req", 64'(o_ram_req), 64'd0);
    chk("mid_rst_stall", 64'(o_stall), 64'd0);
    chk("mid_rst_addr", o_ram_addr, 64'd0);
    chk("mid_rst_wb_en", 64'(o_wb_rd_en), 64'd0);
    chk("mid_rst_ready", 64'(o_id_rd_ready), 64'd0);
    @(posedge i_clk); #1;
    clear_ex();
    i_rst = 1'b0;
    i_ram_ack = 1'b1; i_ram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge i_clk);
    chk("late_ack_req", 64'(o_ram_req), 64'd0);
    chk("late_ack_stall", 64'(o_stall), 64'd0);
    @(posedge i_clk); #1;
    i_ram_ack = 1'b0;
    chk("late_ack_wb_en", 64'(o_wb_rd_en), 64'd0);
    chk("late_ack_wb_reg", o_wb_rd_reg, 64'd0);
    do_alu(1'b1, 5'd9, 64'h77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
